spi_slave_regfile: RTL and testbench

SPI mode-0 slave that terminates the command/data byte frames issued by the team's SPI master and maps them onto a small internal register file. It oversamples SCK, SSB and MOSI with the system clock, decodes an 8-bit command byte followed by one data byte, commits writes or shifts read data back on MISO, and exposes a parallel host read port plus a write-notification strobe.

---
 rtl/spi_slave_regfile_if.sv | 28 ++
 rtl/spi_slave_regfile.sv | 151 +++++++++++++++
 tb/tb_spi_slave_regfile.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_if.sv
// SPI pin and host-side signal bundle for spi_slave_regfile.
// The master modport is the SPI master / host; the slave modport is the register file.
interface spi_slave_regfile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  SCK;
    logic                  SSB;
    logic                  MOSI;
    logic                  MISO;
    logic                  miso_oe;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  wr_strobe;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  frame_abort;

    modport master (
        output SCK, SSB, MOSI, host_addr,
        input  MISO, miso_oe, host_rdata, wr_strobe, wr_addr, wr_data, frame_abort
    );

    modport slave (
        input  SCK, SSB, MOSI, host_addr,
        output MISO, miso_oe, host_rdata, wr_strobe, wr_addr, wr_data, frame_abort
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave: command byte + data byte(s) mapped onto a register file.
// Define SPI_SLAVE_AUTOINC_EN to continue bursts at incrementing addresses.
module spi_slave_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic               clk,
    input logic               reset,
    spi_slave_regfile_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;
    localparam int RX_W  = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
    localparam int NREG  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            sck_s, ssb_s;
    logic [1:0]            mosi_s;
    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic [RX_W-2:0]       rx_shift;
    logic [RX_W-1:0]       rx_next;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr, tx_addr;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] regs [NREG];
    logic                  wr_strobe_r, frame_abort_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    logic sck_rise, sck_fall, ssb_rise, ssb_fall, bit_rise, bit_fall;
    logic byte_last, byte_done, do_write, load_tx, abort;

    // Synchronizers run freely so reset cannot fabricate an SSB edge.
    always_ff @(posedge clk) begin
        sck_s  <= {sck_s[1:0], bus.SCK};
        ssb_s  <= {ssb_s[1:0], bus.SSB};
        mosi_s <= {mosi_s[0], bus.MOSI};
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign ssb_rise = ssb_s[1] & ~ssb_s[2];
    assign ssb_fall = ~ssb_s[1] & ssb_s[2];
    assign bit_rise = sck_rise & ~ssb_rise;
    assign bit_fall = sck_fall & ~ssb_rise;
    assign rx_next  = {rx_shift, mosi_s[1]};

    // A frame may only start after SSB has been seen high since reset.
    always_ff @(posedge clk) begin
        if (reset)
            armed <= 1'b0;
        else if (ssb_s[1])
            armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        load_tx   = 1'b0;
        byte_last = (state == CMD) ? (bit_cnt == CNT_W'(7))
                                   : (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        byte_done = bit_rise & byte_last & (state != IDLE);
        abort     = (state != IDLE) && ssb_rise && (bit_cnt != '0);
        case (state)
            IDLE: if (ssb_fall && armed) state_nxt = CMD;
            CMD: begin
                if (ssb_rise)
                    state_nxt = IDLE;
                else if (byte_done) begin
                    state_nxt = DATA;
                    load_tx   = rx_next[7];
                end
            end
            DATA: begin
                if (ssb_rise)
                    state_nxt = IDLE;
                else if (byte_done) begin
                    do_write = ~rw;
`ifdef SPI_SLAVE_AUTOINC_EN
                    load_tx  = rw;
`else
                    state_nxt = IGNORE;
`endif
                end
            end
            IGNORE: if (ssb_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_addr = (state == CMD) ? rx_next[ADDR_WIDTH-1:0] : addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            rw            <= 1'b0;
            addr          <= '0;
            tx_shift      <= '0;
            regs          <= '{default: '0};
            wr_strobe_r   <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
            frame_abort_r <= 1'b0;
        end else begin
            wr_strobe_r   <= do_write;
            frame_abort_r <= abort;
            if (state == IDLE || ssb_rise)
                bit_cnt <= '0;
            else if (bit_rise) begin
                rx_shift <= rx_next[RX_W-2:0];
                bit_cnt  <= byte_last ? '0 : bit_cnt + CNT_W'(1);
            end
            if (state == CMD && byte_done) begin
                rw   <= rx_next[7];
                addr <= rx_next[ADDR_WIDTH-1:0];
            end
`ifdef SPI_SLAVE_AUTOINC_EN
            if (state == DATA && byte_done)
                addr <= addr + ADDR_WIDTH'(1);
`endif
            if (do_write) begin
                regs[addr] <= rx_next[DATA_WIDTH-1:0];
                wr_addr_r  <= addr;
                wr_data_r  <= rx_next[DATA_WIDTH-1:0];
            end
            // The fall right after a load (bit_cnt == 0) must keep the MSB on the line.
            if (load_tx)
                tx_shift <= regs[tx_addr];
            else if (state == DATA && rw && bit_fall && bit_cnt != '0)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign bus.MISO        = (state == DATA) && rw && tx_shift[DATA_WIDTH-1];
    assign bus.miso_oe     = armed & ~ssb_s[1];
    assign bus.host_rdata  = regs[bus.host_addr];
    assign bus.wr_strobe   = wr_strobe_r;
    assign bus.wr_addr     = wr_addr_r;
    assign bus.wr_data     = wr_data_r;
    assign bus.frame_abort = frame_abort_r;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: directed frames plus random frames
// checked against an array model of the register file.
module tb_spi_slave_regfile;
    localparam int H = 6;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    spi_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] model [16];
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    logic [7:0] got_rd [$];
    int         exp_abort = 0;
    logic [7:0] tx_data [4];
    logic       strobe_prev = 1'b0;
    logic       abort_prev  = 1'b0;
`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        bus.SCK  = 1'b0;
        bus.MOSI = b;
        wait_clk(H);
        m = bus.MISO;
        bus.SCK = 1'b1;
        wait_clk(H);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic m;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tx[7-i], m);
            rx = {rx[6:0], m};
        end
    endtask

    task automatic end_frame();
        bus.SCK = 1'b0;
        wait_clk(H);
        bus.SSB = 1'b1;
        wait_clk(2 * H);
    endtask

    // Frame model: address from cmd[3:0]; only byte 0 is live unless auto-increment.
    task automatic run_frame(input logic [7:0] cmd, input int ndata, input int abort_bits);
        logic [7:0] rx;
        logic [3:0] a;
        bus.SSB = 1'b0;
        wait_clk(H);
        check("miso_oe_selected", bus.miso_oe, 1);
        exp_rd.push_back(8'h00);
        spi_byte(cmd, 8, rx);
        got_rd.push_back(rx);
        for (int i = 0; i < ndata; i++) begin
            a = cmd[3:0] + 4'(i);
            if (i == 0 || AUTOINC) begin
                if (cmd[7]) begin
                    exp_rd.push_back(model[a]);
                end else begin
                    exp_rd.push_back(8'h00);
                    exp_wr.push_back('{a: a, d: tx_data[i]});
                    model[a] = tx_data[i];
                end
            end else begin
                exp_rd.push_back(8'h00);
            end
            spi_byte(tx_data[i], 8, rx);
            got_rd.push_back(rx);
        end
        if (abort_bits > 0) begin
            exp_abort++;
            spi_byte(8'hFF, abort_bits, rx);
        end
        end_frame();
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            bus.host_addr = 4'(i);
            #1;
            check("host_rdata", bus.host_rdata, model[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_MISO", bus.MISO, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        check("rst_wr_strobe", bus.wr_strobe, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_frame_abort", bus.frame_abort, 0);
    endtask

    // Monitor: compares DUT-presented events against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wr_strobe === 1'b1) begin
                check("wr_strobe_width", strobe_prev, 0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr_strobe", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", bus.wr_addr, e.a);
                    check("wr_data", bus.wr_data, e.d);
                end
            end
            if (bus.frame_abort === 1'b1) begin
                check("abort_width", abort_prev, 0);
                if (exp_abort == 0)
                    check("unexpected_frame_abort", 1, 0);
                else
                    exp_abort--;
            end
            strobe_prev = bus.wr_strobe;
            abort_prev  = bus.frame_abort;
            while (got_rd.size() > 0) begin
                logic [7:0] g;
                g = got_rd.pop_front();
                if (exp_rd.size() == 0)
                    check("unexpected_miso_byte", 1, 0);
                else
                    check("miso_byte", g, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        foreach (model[i]) model[i] = 8'h00;
        bus.SCK = 1'b0;
        bus.SSB = 1'b1;
        bus.MOSI = 1'b0;
        bus.host_addr = '0;
        reset = 1'b1;
        wait_clk(10);
        reset = 1'b0;
        wait_clk(4);
        check_reset_outputs();
        check_regs();

        // Single write.
        tx_data[0] = 8'h22;
        run_frame(8'h01, 1, 0);
        check("wr_addr_hold", bus.wr_addr, 1);
        check("wr_data_hold", bus.wr_data, 8'h22);
        check_regs();

        // Read back.
        tx_data[0] = 8'h00;
        run_frame(8'h81, 1, 0);

        // Abort mid data byte.
        run_frame(8'h03, 0, 5);
        check_regs();

        // Reset in the middle of a command byte.
        bus.SSB = 1'b0;
        wait_clk(H);
        spi_byte(8'h07, 4, rx);
        reset = 1'b1;
        spi_byte(8'h70, 2, rx);
        check_reset_outputs();
        reset = 1'b0;
        foreach (model[i]) model[i] = 8'h00;
        spi_byte(8'h70, 2, rx);
        spi_byte(8'hA5, 8, rx);
        check_reset_outputs();
        end_frame();
        check_regs();
        tx_data[0] = 8'h5A;
        run_frame(8'h05, 1, 0);
        check_regs();

        // Burst across the address wrap.
        tx_data[0] = 8'hAA;
        tx_data[1] = 8'hBB;
        run_frame(8'h0F, 2, 0);
        check_regs();
        run_frame(8'h8F, 2, 0);

        // SSB high: SCK activity must be ignored.
        for (int i = 0; i < 16; i++) begin
            logic m;
            spi_bit(1'($urandom), m);
            check("idle_MISO", m, 0);
            check("idle_miso_oe", bus.miso_oe, 0);
        end
        end_frame();

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int nd, ab;
            cmd = 8'($urandom);
            nd  = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
            run_frame(cmd, nd, ab);
            if (f % 10 == 9) check_regs();
        end

        wait_clk(10);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_aborts", exp_abort, 0);
        check("pending_miso_bytes", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
